// File: rtl/fifo_credit_tx_pkg.sv
// rtl/fifo_credit_tx_pkg.sv - shared types and helpers for the credit transmitter
package fifo_credit_tx_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    ERROR = 2'd2
  } credit_state_t;

  // Counter must hold 0..num inclusive.
  function automatic int credit_width(input int num);
    return $clog2(num + 1);
  endfunction

endpackage

// File: rtl/fifo_credit_tx_credit_counter.sv
// rtl/fifo_credit_tx_credit_counter.sv - saturating up/down credit counter with illegal-return flag
module credit_counter
  import fifo_credit_tx_pkg::*;
#(
  parameter int MAX = 128,
  parameter int W   = credit_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         illegal_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         illegal;
  logic         underflow;

  always_comb begin
    illegal   = inc_i && !dec_i && (count_q == W'(MAX));
    underflow = dec_i && !inc_i && (count_q == '0);
    count_d   = count_q;
    if (!illegal && !underflow)
      count_d = count_q + W'(inc_i) - W'(dec_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= W'(MAX);
    else     count_q <= count_d;
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign illegal_o = illegal;

endmodule

// File: rtl/fifo_credit_tx.sv
// rtl/fifo_credit_tx.sv - credit-gated front end forwarding a valid/ready stream into a FIFO write port
module fifo_credit_tx
  import fifo_credit_tx_pkg::*;
#(
  parameter int NUM   = 128,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         IN_data,
  input  logic                     IN_valid,
  output logic                     OUT_ready,
  output logic [WIDTH-1:0]         OUT_data,
  output logic                     OUT_valid,
  input  logic                     IN_pop,
  output logic [$clog2(NUM+1)-1:0] OUT_credits,
  output logic                     OUT_overflow
);

  localparam int CW = credit_width(NUM);

  credit_state_t    state_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overflow_q;
  logic [CW-1:0]    credits_q;
  logic [CW-1:0]    credits_d;
  logic             illegal;
  logic             send;
  logic             refund;

  assign OUT_ready = (credits_q != '0) && !overflow_q;
  assign send      = IN_valid && OUT_ready;
  // Once in error the pop input is still accepted but must not move the count.
  assign refund    = IN_pop && !overflow_q;

  credit_counter #(.MAX(NUM), .W(CW)) u_credit_counter (
    .clk       (clk),
    .rst       (rst),
    .inc_i     (refund),
    .dec_i     (send),
    .count_o   (credits_q),
    .count_d_o (credits_d),
    .illegal_o (illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= send;
      if (send) data_q <= IN_data;
      if (illegal) begin
        overflow_q <= 1'b1;
        state_q    <= ERROR;
      end else begin
        case (state_q)
          RUN:     if (credits_d == '0) state_q <= STALL;
          STALL:   if (credits_d != '0) state_q <= RUN;
          ERROR:   state_q <= ERROR;
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign OUT_data     = data_q;
  assign OUT_valid    = valid_q;
  assign OUT_credits  = credits_q;
  assign OUT_overflow = overflow_q;

endmodule

// File: doc/fifo_credit_tx.md
# fifo_credit_tx

Transmit-side front end for the team's valid/ready FIFO, whose write side has no backpressure output and therefore must never be written when full. The block accepts a valid/ready stream from upstream and forwards each word to the FIFO write port one cycle later. It gates forwarding on a credit counter: the counter starts at the FIFO depth, is spent per forwarded word, and is refunded per word popped at the FIFO read side. It sits directly in front of each FIFO instance.

## Interface
- NUM, 128: depth of the downstream FIFO; initial and maximum credit count.
- WIDTH, 32: data word width.

- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-high.
- IN_data  input  WIDTH  upstream data.
- IN_valid  input  1  upstream word valid.
- OUT_ready  output  1  upstream may transfer this cycle.
- OUT_data  output  WIDTH  word to FIFO IN_data, registered.
- OUT_valid  output  1  write strobe to FIFO IN_valid, registered.
- IN_pop  input  1  credit return; tie to the FIFO's OUT_valid && IN_ready.
- OUT_credits  output  $clog2(NUM+1)  current credit count, registered.
- OUT_overflow  output  1  sticky error: a credit returned with none outstanding.

## Operation
- Credit counter `credits`, width $clog2(NUM+1), reset value NUM.
- OUT_ready = (credits != 0) && !OUT_overflow. It depends only on registers, with no combinational path from IN_valid.
- An upstream transfer (`send`) occurs when IN_valid && OUT_ready.
- State machine, 3 states:
  - RUN: credits > 0.
  - STALL: credits == 0. OUT_ready is 0.
  - ERROR: entered on overflow. Stays until rst. OUT_ready is 0. IN_pop is still accepted but ignored.
  - Transitions: RUN->STALL when next credits == 0. STALL->RUN when next credits > 0. Any state->ERROR on an illegal return.
- Credit update, per cycle:
  - credits_next = credits - send + IN_pop.
  - send && IN_pop together: count unchanged. This is required at credits == NUM and at credits == 0.
  - A send while credits == 0 cannot occur, because OUT_ready is 0.
  - IN_pop && !send while credits == NUM is an illegal return. Credits stay at NUM. OUT_overflow is set, and the state goes to ERROR.
- Output stage:
  - On send: OUT_data <= IN_data and OUT_valid <= 1.
  - Otherwise: OUT_valid <= 0 and OUT_data holds its previous value.
  - OUT_valid is a single-cycle strobe per word. There is no downstream ready, because the credits guarantee space.
- Width rules:
  - All credit arithmetic is unsigned at counter width.
  - The increment and decrement use 1-bit operands zero-extended to counter width.
  - The counter never wraps.

## Timing
- Reset values: OUT_valid 0, OUT_data 0, OUT_credits NUM, OUT_overflow 0, state RUN. OUT_ready is therefore 1 immediately after rst deasserts.
- Latency: a word accepted at edge n appears with OUT_valid = 1 during the cycle after edge n, and is written into the FIFO at edge n+1.
- Credit effect of IN_pop:
  - IN_pop at edge n updates credits at edge n.
  - OUT_ready can rise in the following cycle, so a full round trip with one credit has 1-cycle turnaround.
- Sustained throughput: 1 word per cycle while credits > 0.
  - With NUM words outstanding and no pops, OUT_ready drops for the cycle after the NUM-th send.
- Reset mid-operation: asynchronous clear to the reset values.
  - In-flight OUT_valid is dropped.
  - The downstream FIFO must be reset by the same rst, or credits desynchronise.
- Back-to-back: sends and pops in the same cycle are both honoured, with no bubble.

## Structure
- The shared stream package holds:
  - `credit_state_t`, an enum {RUN, STALL, ERROR}.
  - A function returning the counter width for a given NUM ($clog2(NUM+1)), shared with the FIFO.
- One sub-module, `credit_counter`: a parameterised up/down counter with saturation at 0 and at MAX, plus an illegal-return flag.
- The top level holds the FSM and the output register.

## Test plan
- Reset release with NUM=4: OUT_ready=1, OUT_credits=4, OUT_valid=0, OUT_data=0.
- Fill with NUM=4: hold IN_valid=1 with data 1,2,3,4,5 and no IN_pop. Required:
  - Four OUT_valid strobes carrying 1..4, each one cycle after acceptance.
  - OUT_ready=0 from the cycle after the 4th send.
  - Word 5 is held upstream and OUT_credits=0.
- Refund: in the state above, pulse IN_pop once.
  - Credits become 1 and OUT_ready=1 next cycle.
  - Word 5 is forwarded, and credits return to 0.
- Simultaneous send and pop:
  - At credits=0 the pair cannot occur, since send is blocked. Check instead that a pop alone gives credits 0->1.
  - At credits=2, send and pop in the same cycle: credits stay 2 and OUT_valid is 1 the next cycle.
- Illegal return: IN_pop with credits=NUM and no send. Required:
  - OUT_overflow=1 next cycle and stays 1.
  - OUT_ready=0 and credits=NUM.
  - Cleared only by rst.
- Reset mid-burst: assert rst asynchronously between edges while OUT_valid=1 and credits=1. Required:
  - OUT_valid=0 immediately.
  - Credits return to NUM with no clock edge.
